bitty_fetch: RTL and testbench

BITTY_FETCH -- requirements
Module: bitty_fetch

---
 rtl/bitty_fetch_if.sv | 43 ++++
 rtl/bitty_fetch.sv | 113 +++++++++++
 tb/tb_bitty_fetch.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bitty_fetch_if.sv
// -----------------------------------------------------------------------------
// bitty_fetch_if -- bus bundle between the bitty_fetch sequencer and its user
// (program loader + execution core).
//
//   start        user -> fetch   begin/restart program execution
//   end_addr     user -> fetch   address of the last program instruction
//   load_en      user -> fetch   program-memory write strobe
//   load_addr    user -> fetch   program-memory write address
//   load_data    user -> fetch   program-memory write data (16 bit)
//   done         user -> fetch   core completion pulse for issued instruction
//   run          fetch -> user   one-cycle "instruction valid, execute" pulse
//   instruction  fetch -> user   registered instruction word
//   pc           fetch -> user   address of current / next instruction
//   busy         fetch -> user   sequencer is fetching, issuing or waiting
//   halted       fetch -> user   program reached end_addr and stopped
//
// Modports: slave = the fetch unit, master = the loader/core side.
// -----------------------------------------------------------------------------
interface bitty_fetch_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] end_addr;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [15:0]       load_data;
    logic              done;
    logic              run;
    logic [15:0]       instruction;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              halted;

    modport slave (
        input  start, end_addr, load_en, load_addr, load_data, done,
        output run, instruction, pc, busy, halted
    );

    modport master (
        output start, end_addr, load_en, load_addr, load_data, done,
        input  run, instruction, pc, busy, halted
    );
endinterface

// File: rtl/bitty_fetch.sv
// -----------------------------------------------------------------------------
// bitty_fetch -- instruction fetch / issue sequencer with a private program
// memory of 2^ADDR_W x 16-bit words.
//
// Ports:
//   clk    single clock, all state updates on its rising edge
//   reset  synchronous, active-high reset (wins over every other input)
//   bus    bitty_fetch_if.slave (see the interface file for signal list)
//
// Operation: IDLE/HALT accept program loads and a start request. Start sends
// the sequencer to FETCH at pc=0; FETCH reads mem[pc] synchronously, ISSUE
// presents the word with a one-cycle run pulse, WAIT holds it until the core
// reports done, after which the sequencer either halts (pc == end_addr) or
// steps pc (wrapping) and fetches again.
// -----------------------------------------------------------------------------
module bitty_fetch #(
    parameter int ADDR_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    bitty_fetch_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_HALT
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [15:0]       instr_q;
    logic              run_q;
    logic              busy_q;
    logic              halted_q;

    // Program memory: no reset, contents only change through loads.
    logic [15:0] mem [0:DEPTH-1];
    logic        load_ok;

    // Loads are only honoured while the sequencer is parked, so the memory is
    // never written while an instruction may be in flight.
    assign load_ok = bus.load_en && !reset &&
                     ((state_q == S_IDLE) || (state_q == S_HALT));

    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[bus.load_addr] <= bus.load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            instr_q  <= 16'h0000;
            run_q    <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            run_q <= 1'b0;
            case (state_q)
                S_IDLE, S_HALT: begin
                    if (bus.start) begin
                        state_q  <= S_FETCH;
                        pc_q     <= '0;
                        busy_q   <= 1'b1;
                        halted_q <= 1'b0;
                    end
                end
                S_FETCH: begin
                    // The synchronous memory read lands directly in the
                    // instruction register on the edge that enters ISSUE, so
                    // the word and the run pulse appear together and the word
                    // is untouched for the whole of WAIT.
                    instr_q <= mem[pc_q];
                    run_q   <= 1'b1;
                    state_q <= S_ISSUE;
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.done) begin
                        if (pc_q == bus.end_addr) begin
                            state_q  <= S_HALT;
                            busy_q   <= 1'b0;
                            halted_q <= 1'b1;
                        end else begin
                            // Natural ADDR_W-bit overflow gives the wrap to 0.
                            pc_q    <= pc_q + 1'b1;
                            state_q <= S_FETCH;
                        end
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    busy_q   <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.run         = run_q;
    assign bus.instruction = instr_q;
    assign bus.pc          = pc_q;
    assign bus.busy        = busy_q;
    assign bus.halted      = halted_q;
endmodule

// File: tb/tb_bitty_fetch.sv
// -----------------------------------------------------------------------------
// tb_bitty_fetch -- self-checking bench for bitty_fetch (ADDR_W = 2).
// The reference model is transaction level: a 4-word program memory array and
// the rule "issue addr, then halt if addr == end_addr, else go to (addr+1)%4",
// plus the run-timing rule "run appears two cycles after start/done is taken".
// -----------------------------------------------------------------------------
module tb_bitty_fetch;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    bitty_fetch_if #(.ADDR_W(AW)) u_if ();

    bitty_fetch #(.ADDR_W(AW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    // Reference program memory.
    logic [15:0] model_mem [DEPTH];

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;

    // Run-pulse monitor state.
    int          run_count     = 0;
    int          last_run_edge = -10;
    logic [15:0] last_run_instr;
    logic [AW-1:0] last_run_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(negedge clk) begin
        if (u_if.run === 1'b1) begin
            chk("run_gap", 32'((edge_n - last_run_edge) > 1), 32'd1);
            run_count      = run_count + 1;
            last_run_edge  = edge_n;
            last_run_instr = u_if.instruction;
            last_run_pc    = u_if.pc;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        u_if.start   = 1'b0;
        u_if.load_en = 1'b0;
        u_if.done    = 1'b0;
    endtask

    // Random start/load noise that the sequencer must ignore while busy.
    task automatic busy_noise();
        u_if.start     = 1'($urandom_range(0, 1));
        u_if.load_en   = 1'($urandom_range(0, 1));
        u_if.load_addr = AW'($urandom_range(0, DEPTH - 1));
        u_if.load_data = 16'($urandom);
    endtask

    // Reset with every other control input asserted: reset must win.
    task automatic do_reset();
        reset          = 1'b1;
        u_if.start     = 1'b1;
        u_if.done      = 1'b1;
        u_if.load_en   = 1'b1;
        u_if.load_addr = AW'($urandom_range(0, DEPTH - 1));
        u_if.load_data = 16'($urandom);
        step();
        reset = 1'b0;
        idle_inputs();
        chk("rst_busy",   u_if.busy,        0);
        chk("rst_halted", u_if.halted,      0);
        chk("rst_run",    u_if.run,         0);
        chk("rst_pc",     u_if.pc,          0);
        chk("rst_instr",  u_if.instruction, 0);
    endtask

    task automatic load_word(input int a, input logic [15:0] d);
        u_if.load_en   = 1'b1;
        u_if.load_addr = AW'(a);
        u_if.load_data = d;
        step();
        u_if.load_en   = 1'b0;
        model_mem[a]   = d;
    endtask

    // Caller has just driven the accepted start/done; expect the issue of
    // exp_addr exactly two cycles later. Optionally pulse done during ISSUE.
    task automatic expect_issue(input int exp_addr, input bit issue_done);
        int e0;
        int rc;
        e0 = edge_n;
        rc = run_count;
        step();                       // start/done sampled -> FETCH
        busy_noise();
        u_if.done = 1'($urandom_range(0, 1));
        step();                       // -> ISSUE
        busy_noise();
        u_if.done = issue_done;
        step();                       // -> WAIT
        idle_inputs();
        chk("run_cnt",  32'(run_count - rc),  1);
        chk("run_edge", 32'(last_run_edge),   32'(e0 + 2));
        chk("run_inst", last_run_instr,       model_mem[exp_addr]);
        chk("run_pc",   last_run_pc,          32'(exp_addr));
        chk("wait_busy", u_if.busy,           1);
    endtask

    // Stay in WAIT a random while, then drive done (sampled on the next edge).
    task automatic wait_phase(input int exp_addr);
        int n;
        int rc;
        n  = $urandom_range(0, 3);
        rc = run_count;
        repeat (n) begin
            busy_noise();
            step();
            chk("hold_inst", u_if.instruction, model_mem[exp_addr]);
        end
        idle_inputs();
        chk("wait_norun", 32'(run_count - rc), 0);
        u_if.done = 1'b1;
    endtask

    // Start a program (optionally loading a word in the same cycle) and follow
    // it to HALT. end_addr switches to end_second before instruction sw_idx.
    task automatic run_prog(input int end_first, input int sw_idx, input int end_second,
                            input bit with_load, input int la, input logic [15:0] ld,
                            output int issued);
        int  addr;
        bit  fin;
        int  rc;
        addr   = 0;
        fin    = 1'b0;
        issued = 0;
        if (with_load) begin
            u_if.load_en   = 1'b1;
            u_if.load_addr = AW'(la);
            u_if.load_data = ld;
            model_mem[la]  = ld;
        end
        u_if.end_addr = AW'(end_first);
        u_if.start    = 1'b1;
        for (int i = 0; i < 12 && !fin; i++) begin
            if (i == sw_idx) u_if.end_addr = AW'(end_second);
            expect_issue(addr, $urandom_range(0, 3) == 0);
            issued++;
            wait_phase(addr);
            if (addr == int'(u_if.end_addr)) begin
                rc = run_count;
                step();
                u_if.done = 1'b0;
                chk("halt_flag", u_if.halted, 1);
                chk("halt_busy", u_if.busy,   0);
                chk("halt_pc",   u_if.pc,     32'(addr));
                step();
                chk("halt_norun", 32'(run_count - rc), 0);
                fin = 1'b1;
            end else begin
                addr = (addr + 1) % DEPTH;
            end
        end
        chk("prog_halted", 32'(fin), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int issued;
        int rc;
        int e;
        u_if.end_addr  = '0;
        u_if.load_addr = '0;
        u_if.load_data = '0;
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 16'h0;
        step();
        do_reset();

        // done in IDLE must do nothing.
        u_if.done = 1'b1;
        step();
        u_if.done = 1'b0;
        step();
        chk("idle_done_pc",   u_if.pc,   0);
        chk("idle_done_busy", u_if.busy, 0);
        chk("idle_done_halt", u_if.halted, 0);

        // Three-instruction program.
        for (int i = 0; i < DEPTH; i++) load_word(i, 16'h0);
        load_word(0, 16'h1111);
        load_word(1, 16'h2222);
        load_word(2, 16'h3333);
        rc = run_count;
        run_prog(2, -1, 0, 1'b0, 0, 16'h0, issued);
        chk("p3_runs", 32'(run_count - rc), 3);
        chk("p3_issued", 32'(issued), 3);

        // Load in HALT together with start: first word issued is the new one.
        run_prog(0, -1, 0, 1'b1, 0, 16'hBEEF, issued);
        chk("beef_issued", 32'(issued), 1);

        // Load attempt during WAIT must not reach memory.
        u_if.end_addr = AW'(1);
        u_if.start    = 1'b1;
        expect_issue(0, 1'b1);
        u_if.load_en   = 1'b1;
        u_if.load_addr = '0;
        u_if.load_data = 16'h0BAD;
        step();
        idle_inputs();
        u_if.done = 1'b1;
        expect_issue(1, 1'b0);
        u_if.done = 1'b1;
        step();
        idle_inputs();
        chk("wl_halt", u_if.halted, 1);
        u_if.end_addr = '0;
        u_if.start    = 1'b1;
        expect_issue(0, 1'b0);   // still BEEF in the model
        u_if.done = 1'b1;
        step();
        idle_inputs();

        // pc wrap: 0,1,2,3,0,1 with end_addr moved to 1 once pc reaches 3.
        for (int i = 0; i < DEPTH; i++) load_word(i, 16'($urandom));
        rc = run_count;
        run_prog(3, 3, 1, 1'b0, 0, 16'h0, issued);
        chk("wrap_runs", 32'(run_count - rc), 6);

        // Reset in WAIT abandons the instruction; late done ignored.
        load_word(0, 16'hABCD);
        u_if.end_addr = AW'(3);
        u_if.start    = 1'b1;
        expect_issue(0, 1'b0);
        chk("abcd_inst", u_if.instruction, 16'hABCD);
        rc = run_count;
        do_reset();
        u_if.done = 1'b1;
        step();
        u_if.done = 1'b0;
        repeat (3) step();
        chk("rw_inst", u_if.instruction, 0);
        chk("rw_pc",   u_if.pc,          0);
        chk("rw_busy", u_if.busy,        0);
        chk("rw_halt", u_if.halted,      0);
        chk("rw_norun", 32'(run_count - rc), 0);

        // Randomised programs.
        for (int t = 0; t < 15; t++) begin
            for (int i = 0; i < DEPTH; i++)
                if ($urandom_range(0, 1) == 1) load_word(i, 16'($urandom));
            e = $urandom_range(0, DEPTH - 1);
            run_prog(e, -1, 0, 1'($urandom_range(0, 1)),
                     $urandom_range(0, DEPTH - 1), 16'($urandom), issued);
            chk("rnd_issued", 32'(issued), 32'(e + 1));
            if ($urandom_range(0, 3) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
